// File: rtl/graphics_pkg.sv
`default_nettype none
// ============================================================================
// Module  : graphics_pkg
// Brief   : VGA 640x480@60 timing defaults and colour palette shared with the
//           sprite renderers.
// Rev     : 1.0
// ============================================================================
package graphics_pkg;

    localparam int COORD_W = 16;
    localparam int COLOR_W = 24;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam logic [COLOR_W-1:0] BLACK = 24'h000000;
    localparam logic [COLOR_W-1:0] WHITE = 24'hFFFFFF;
    localparam logic [COLOR_W-1:0] GRAY  = 24'h808080;
    localparam logic [COLOR_W-1:0] RED   = 24'hFF0000;
    localparam logic [COLOR_W-1:0] GREEN = 24'h00FF00;
    localparam logic [COLOR_W-1:0] BLUE  = 24'h0000FF;

    // Inclusive window test used for the sync pulses.
    function automatic logic in_range(input logic [COORD_W-1:0] val,
                                      input logic [COORD_W-1:0] lo,
                                      input logic [COORD_W-1:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : vga_timing_gen_if
// Brief   : Scan coordinates / colour return from the renderers and the
//           registered video signals toward the DAC.
// Rev     : 1.0
// ============================================================================
interface vga_timing_gen_if;
    import graphics_pkg::*;

    logic [COORD_W-1:0] pixel_x;
    logic [COORD_W-1:0] pixel_y;
    logic               pix_en;
    logic               frame_start;
    logic [COLOR_W-1:0] color_in;
    logic [COLOR_W-1:0] rgb_out;
    logic               hsync;
    logic               vsync;
    logic               blank;

    modport master (
        output pixel_x, pixel_y, pix_en, frame_start,
        output rgb_out, hsync, vsync, blank,
        input  color_in
    );

    modport slave (
        input  pixel_x, pixel_y, pix_en, frame_start,
        input  rgb_out, hsync, vsync, blank,
        output color_in
    );
endinterface
`default_nettype wire

// File: rtl/vga_pix_div.sv
`default_nettype none
// ============================================================================
// Module  : vga_pix_div
// Brief   : System-clock divider producing the one-clock pixel enable.
// Rev     : 1.0
// ============================================================================
module vga_pix_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic pix_en
);
    localparam int               CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;

    always_comb begin
        div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // Gating with rst keeps the enable low in the reset clock even when CLK_DIV=1.
    assign pix_en = ~rst && (div_cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module  : vga_timing_gen
// Brief   : 640x480 scan counters plus registered RGB/sync/blank output stage.
// Rev     : 1.0
// ============================================================================
module vga_timing_gen
    import graphics_pkg::*;
#(
    parameter int   H_ACTIVE    = VGA_H_ACTIVE,
    parameter int   H_FP        = VGA_H_FP,
    parameter int   H_SYNC      = VGA_H_SYNC,
    parameter int   H_BP        = VGA_H_BP,
    parameter int   V_ACTIVE    = VGA_V_ACTIVE,
    parameter int   V_FP        = VGA_V_FP,
    parameter int   V_SYNC      = VGA_V_SYNC,
    parameter int   V_BP        = VGA_V_BP,
    parameter int   CLK_DIV     = 2,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST    = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT_END = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT_END = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] H_SYNC_LO = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] H_SYNC_HI = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] V_SYNC_LO = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] V_SYNC_HI = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic               pix_en;
    logic [COORD_W-1:0] h_q, h_d;
    logic [COORD_W-1:0] v_q, v_d;
    logic [COLOR_W-1:0] rgb_q, rgb_d;
    logic               blank_q, blank_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               h_wrap;
    logic               active;

    vga_pix_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_div (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en)
    );

    assign h_wrap = (h_q == H_LAST);
    assign active = (h_q < H_ACT_END) && (v_q < V_ACT_END);

    always_comb begin
        h_d     = h_q;
        v_d     = v_q;
        rgb_d   = rgb_q;
        blank_d = blank_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        if (pix_en) begin
            h_d = h_wrap ? '0 : h_q + 1'b1;
            if (h_wrap) begin
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end
            // Output stage samples the pixel the counters are leaving.
            blank_d = ~active;
            rgb_d   = active ? vga.color_in : BLACK;
            hsync_d = in_range(h_q, H_SYNC_LO, H_SYNC_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync_d = in_range(v_q, V_SYNC_LO, V_SYNC_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q     <= '0;
            v_q     <= '0;
            rgb_q   <= BLACK;
            blank_q <= 1'b1;
            hsync_q <= ~SYNC_ACTIVE;
            vsync_q <= ~SYNC_ACTIVE;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            rgb_q   <= rgb_d;
            blank_q <= blank_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign vga.pixel_x     = h_q;
    assign vga.pixel_y     = v_q;
    assign vga.pix_en      = pix_en;
    assign vga.frame_start = pix_en && (h_q == '0) && (v_q == '0);
    assign vga.rgb_out     = rgb_q;
    assign vga.blank       = blank_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_timing_gen
// Brief   : Scoreboard bench: full-size timing at CLK_DIV=2 and 1, plus a
//           shrunken active-high-sync instance for whole-frame behaviour.
// Rev     : 1.0
// ============================================================================
module tb_vga_timing_gen;
    import graphics_pkg::*;

    localparam int A_DIV = 2;
    localparam int B_DIV = 1;
    localparam int C_DIV = 3;
    localparam int C_HA = 8, C_HF = 2, C_HS = 3, C_HB = 2;
    localparam int C_VA = 6, C_VF = 2, C_VS = 2, C_VB = 1;
    localparam int C_HT = C_HA + C_HF + C_HS + C_HB;
    localparam int C_VT = C_VA + C_VF + C_VS + C_VB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic [23:0] col_a = '0, col_b = '0, col_c = '0;

    int n_cmp = 0;
    int n_bad = 0;

    vga_timing_gen_if ifa ();
    vga_timing_gen_if ifb ();
    vga_timing_gen_if ifc ();
    assign ifa.color_in = col_a;
    assign ifb.color_in = col_b;
    assign ifc.color_in = col_c;

    vga_timing_gen #(.CLK_DIV(A_DIV), .SYNC_ACTIVE(1'b0)) dut_a (.clk(clk), .rst(rst_a), .vga(ifa.master));
    vga_timing_gen #(.CLK_DIV(B_DIV), .SYNC_ACTIVE(1'b0)) dut_b (.clk(clk), .rst(rst_b), .vga(ifb.master));
    vga_timing_gen #(
        .H_ACTIVE(C_HA), .H_FP(C_HF), .H_SYNC(C_HS), .H_BP(C_HB),
        .V_ACTIVE(C_VA), .V_FP(C_VF), .V_SYNC(C_VS), .V_BP(C_VB),
        .CLK_DIV(C_DIV), .SYNC_ACTIVE(1'b1)
    ) dut_c (.clk(clk), .rst(rst_c), .vga(ifc.master));

    // Expected {pix_en, x, y, frame_start} after c clock edges since release.
    function automatic logic [33:0] exp_tim(input int c, input int div, input int ht, input int vt);
        int idx, x, y;
        logic pe;
        idx = c / div;
        pe  = ((c + 1) % div) == 0;
        x   = idx % ht;
        y   = (idx / ht) % vt;
        return {pe, x[15:0], y[15:0], pe && (x == 0) && (y == 0)};
    endfunction

    // Expected registered {blank, hsync, vsync, rgb} for one scanned pixel.
    function automatic logic [26:0] exp_vid(input int h, input int v, input int ha, input int hf,
                                            input int hs, input int va, input int vf, input int vs,
                                            input logic sa, input logic [23:0] col);
        logic act, hsy, vsy;
        act = (h < ha) && (v < va);
        hsy = (h >= ha + hf && h < ha + hf + hs) ? sa : ~sa;
        vsy = (v >= va + vf && v < va + vf + vs) ? sa : ~sa;
        return {~act, hsy, vsy, act ? col : 24'h000000};
    endfunction

    // ---------------- scoreboard monitors (one per instance) ----------------
    int c_a = 0, c_b = 0, c_c = 0;
    logic [26:0] q_a[$], q_b[$], q_c[$];
    logic [26:0] cur_a, cur_b, cur_c;
    logic [33:0] et_a, et_b, et_c;

    always @(negedge clk) begin
        if (rst_a) begin
            c_a = 0; q_a.delete(); cur_a = {3'b111, 24'h0}; et_a = '0;
        end else begin
            et_a = exp_tim(c_a, A_DIV, VGA_H_TOTAL, VGA_V_TOTAL);
            if (c_a > 0 && c_a % A_DIV == 0) begin
                n_cmp++;
                if (q_a.size() == 0) begin n_bad++; $display("FAIL mon_a_queue: empty at c=%0d, need one entry", c_a); end
                else cur_a = q_a.pop_front();
            end
        end
        n_cmp++;
        if ({ifa.pix_en, ifa.pixel_x, ifa.pixel_y, ifa.frame_start} !== et_a) begin
            n_bad++;
            $display("FAIL mon_a_timing c=%0d: got pe=%b x=%0d y=%0d fs=%b, want pe=%b x=%0d y=%0d fs=%b", c_a,
                     ifa.pix_en, ifa.pixel_x, ifa.pixel_y, ifa.frame_start, et_a[33], et_a[32:17], et_a[16:1], et_a[0]);
        end
        n_cmp++;
        if ({ifa.blank, ifa.hsync, ifa.vsync, ifa.rgb_out} !== cur_a) begin
            n_bad++;
            $display("FAIL mon_a_video c=%0d: got %h want %h", c_a, {ifa.blank, ifa.hsync, ifa.vsync, ifa.rgb_out}, cur_a);
        end
        if (!rst_a) begin
            if (et_a[33]) q_a.push_back(exp_vid(int'(et_a[32:17]), int'(et_a[16:1]), VGA_H_ACTIVE, VGA_H_FP,
                                                VGA_H_SYNC, VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, 1'b0, col_a));
            c_a++;
        end
    end

    always @(negedge clk) begin
        if (rst_b) begin
            c_b = 0; q_b.delete(); cur_b = {3'b111, 24'h0}; et_b = '0;
        end else begin
            et_b = exp_tim(c_b, B_DIV, VGA_H_TOTAL, VGA_V_TOTAL);
            if (c_b > 0 && c_b % B_DIV == 0) begin
                n_cmp++;
                if (q_b.size() == 0) begin n_bad++; $display("FAIL mon_b_queue: empty at c=%0d, need one entry", c_b); end
                else cur_b = q_b.pop_front();
            end
        end
        n_cmp++;
        if ({ifb.pix_en, ifb.pixel_x, ifb.pixel_y, ifb.frame_start} !== et_b) begin
            n_bad++;
            $display("FAIL mon_b_timing c=%0d: got pe=%b x=%0d y=%0d fs=%b, want pe=%b x=%0d y=%0d fs=%b", c_b,
                     ifb.pix_en, ifb.pixel_x, ifb.pixel_y, ifb.frame_start, et_b[33], et_b[32:17], et_b[16:1], et_b[0]);
        end
        n_cmp++;
        if ({ifb.blank, ifb.hsync, ifb.vsync, ifb.rgb_out} !== cur_b) begin
            n_bad++;
            $display("FAIL mon_b_video c=%0d: got %h want %h", c_b, {ifb.blank, ifb.hsync, ifb.vsync, ifb.rgb_out}, cur_b);
        end
        if (!rst_b) begin
            if (et_b[33]) q_b.push_back(exp_vid(int'(et_b[32:17]), int'(et_b[16:1]), VGA_H_ACTIVE, VGA_H_FP,
                                                VGA_H_SYNC, VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, 1'b0, col_b));
            c_b++;
        end
    end

    always @(negedge clk) begin
        if (rst_c) begin
            c_c = 0; q_c.delete(); cur_c = {3'b100, 24'h0}; et_c = '0;
        end else begin
            et_c = exp_tim(c_c, C_DIV, C_HT, C_VT);
            if (c_c > 0 && c_c % C_DIV == 0) begin
                n_cmp++;
                if (q_c.size() == 0) begin n_bad++; $display("FAIL mon_c_queue: empty at c=%0d, need one entry", c_c); end
                else cur_c = q_c.pop_front();
            end
        end
        n_cmp++;
        if ({ifc.pix_en, ifc.pixel_x, ifc.pixel_y, ifc.frame_start} !== et_c) begin
            n_bad++;
            $display("FAIL mon_c_timing c=%0d: got pe=%b x=%0d y=%0d fs=%b, want pe=%b x=%0d y=%0d fs=%b", c_c,
                     ifc.pix_en, ifc.pixel_x, ifc.pixel_y, ifc.frame_start, et_c[33], et_c[32:17], et_c[16:1], et_c[0]);
        end
        n_cmp++;
        if ({ifc.blank, ifc.hsync, ifc.vsync, ifc.rgb_out} !== cur_c) begin
            n_bad++;
            $display("FAIL mon_c_video c=%0d: got %h want %h", c_c, {ifc.blank, ifc.hsync, ifc.vsync, ifc.rgb_out}, cur_c);
        end
        if (!rst_c) begin
            if (et_c[33]) q_c.push_back(exp_vid(int'(et_c[32:17]), int'(et_c[16:1]), C_HA, C_HF, C_HS,
                                                C_VA, C_VF, C_VS, 1'b1, col_c));
            c_c++;
        end
    end

    // ---------------- stimulus helpers and scenarios ----------------
    // Returns just after the releasing edge; the next negedge is c=0.
    task automatic do_reset(input int which, input logic [23:0] col);
        @(posedge clk); #2;
        case (which)
            0:       begin rst_a = 1'b1; col_a = col; end
            1:       begin rst_b = 1'b1; col_b = col; end
            default: begin rst_c = 1'b1; col_c = col; end
        endcase
        repeat (2) @(posedge clk);
        #2;
        case (which)
            0:       rst_a = 1'b0;
            1:       rst_b = 1'b0;
            default: rst_c = 1'b0;
        endcase
    endtask

    task automatic test_reset;
        @(posedge clk); #2; rst_a = 1'b1; col_a = BLUE;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({ifa.pix_en, ifa.pixel_x, ifa.pixel_y, ifa.frame_start, ifa.blank, ifa.hsync, ifa.vsync, ifa.rgb_out}
            !== {1'b0, 16'd0, 16'd0, 1'b0, 3'b111, 24'h0}) begin
            n_bad++; $display("FAIL reset_state: got pe=%b x=%0d y=%0d blank=%b rgb=%h, want 0/0/0/1/000000",
                              ifa.pix_en, ifa.pixel_x, ifa.pixel_y, ifa.blank, ifa.rgb_out);
        end
        @(posedge clk); #2; rst_a = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ifa.pix_en !== 1'b0 || ifa.blank !== 1'b1) begin
            n_bad++; $display("FAIL reset_release_hold: got pe=%b blank=%b, want 0/1", ifa.pix_en, ifa.blank);
        end
        @(negedge clk);
        n_cmp++;
        if ({ifa.pix_en, ifa.pixel_x, ifa.pixel_y, ifa.frame_start} !== {1'b1, 16'd0, 16'd0, 1'b1}) begin
            n_bad++; $display("FAIL first_pulse: got pe=%b x=%0d y=%0d fs=%b, want 1/0/0/1",
                              ifa.pix_en, ifa.pixel_x, ifa.pixel_y, ifa.frame_start);
        end
        n_cmp++;
        if ({ifa.blank, ifa.rgb_out} !== {1'b1, 24'h0}) begin
            n_bad++; $display("FAIL hold_until_pulse: got blank=%b rgb=%h, want 1/000000", ifa.blank, ifa.rgb_out);
        end
        @(negedge clk);
        n_cmp++;
        if ({ifa.blank, ifa.rgb_out} !== {1'b0, BLUE}) begin
            n_bad++; $display("FAIL first_capture: got blank=%b rgb=%h, want 0/0000ff", ifa.blank, ifa.rgb_out);
        end
    endtask

    task automatic test_line;
        int hs_cnt, pulses, first_hs, last_hs, px;
        logic prev_pe;
        hs_cnt = 0; pulses = 0; first_hs = -1; last_hs = -1; px = 0; prev_pe = 1'b0;
        do_reset(0, BLUE);
        for (int i = 0; i <= 2 * VGA_H_TOTAL; i++) begin
            @(negedge clk);
            if (prev_pe === 1'b1 && ifa.hsync === 1'b0) begin
                hs_cnt++;
                if (first_hs < 0) first_hs = px;
                last_hs = px;
            end
            if (ifa.pix_en === 1'b1) begin pulses++; px = int'(ifa.pixel_x); end
            prev_pe = ifa.pix_en;
        end
        n_cmp++;
        if (pulses != 800) begin n_bad++; $display("FAIL line_pulses: got %0d want 800", pulses); end
        n_cmp++;
        if (hs_cnt != 96) begin n_bad++; $display("FAIL hsync_width: got %0d want 96", hs_cnt); end
        n_cmp++;
        if (first_hs != 656 || last_hs != 751) begin
            n_bad++; $display("FAIL hsync_window: got %0d..%0d want 656..751", first_hs, last_hs);
        end
        @(negedge clk);
        n_cmp++;
        if ({ifa.pix_en, ifa.pixel_x, ifa.pixel_y, ifa.frame_start} !== {1'b1, 16'd0, 16'd1, 1'b0}) begin
            n_bad++; $display("FAIL line_wrap: got pe=%b x=%0d y=%0d fs=%b, want 1/0/1/0",
                              ifa.pix_en, ifa.pixel_x, ifa.pixel_y, ifa.frame_start);
        end
    endtask

    task automatic test_blue;
        int act_cnt, blk_cnt;
        act_cnt = 0; blk_cnt = 0;
        do_reset(0, BLUE);
        for (int i = 0; i <= 2 * VGA_H_TOTAL; i++) begin
            @(negedge clk);
            if (i > 0 && i % 2 == 0) begin
                if ({ifa.blank, ifa.rgb_out} === {1'b0, BLUE}) act_cnt++;
                if ({ifa.blank, ifa.rgb_out} === {1'b1, 24'h0}) blk_cnt++;
            end
        end
        n_cmp++;
        if (act_cnt != 640) begin n_bad++; $display("FAIL blue_active: got %0d want 640", act_cnt); end
        n_cmp++;
        if (blk_cnt != 160) begin n_bad++; $display("FAIL blue_blanked: got %0d want 160", blk_cnt); end
    endtask

    task automatic test_back_to_back;
        logic [23:0] exp_q[$];
        logic [23:0] want;
        do_reset(0, 24'h0);
        for (int i = 0; i <= 2 * VGA_H_TOTAL; i++) begin
            @(negedge clk);
            if (i > 0 && i % 2 == 0 && exp_q.size() > 0) begin
                want = exp_q.pop_front();
                n_cmp++;
                if (ifa.rgb_out !== want) begin
                    n_bad++; $display("FAIL rand_rgb c=%0d: got %h want %h", i, ifa.rgb_out, want);
                end
            end
            if (i % 2 == 1) exp_q.push_back(((i - 1) / 2 < VGA_H_ACTIVE) ? col_a : 24'h0);
            @(posedge clk); #2;
            col_a = 24'($urandom);
        end
    endtask

    task automatic test_frame;
        int fs_cnt, vs_cnt, hs_cnt, wraps, px, py;
        logic prev_pe;
        fs_cnt = 0; vs_cnt = 0; hs_cnt = 0; wraps = 0; px = 0; py = 0; prev_pe = 1'b0;
        do_reset(2, GRAY);
        for (int i = 0; i < 2 * C_HT * C_VT * C_DIV; i++) begin
            @(negedge clk);
            if (prev_pe === 1'b1) begin
                if (ifc.vsync === 1'b1) vs_cnt++;
                if (ifc.hsync === 1'b1) hs_cnt++;
                if (px == C_HT - 1 && py == C_VT - 1) begin
                    wraps++;
                    n_cmp++;
                    if (ifc.pixel_x !== 16'd0 || ifc.pixel_y !== 16'd0) begin
                        n_bad++; $display("FAIL frame_wrap: got x=%0d y=%0d want 0/0", ifc.pixel_x, ifc.pixel_y);
                    end
                end
            end
            if (ifc.frame_start === 1'b1) fs_cnt++;
            px = int'(ifc.pixel_x); py = int'(ifc.pixel_y);
            prev_pe = ifc.pix_en;
        end
        n_cmp++;
        if (fs_cnt != 2) begin n_bad++; $display("FAIL frame_start_count: got %0d want 2", fs_cnt); end
        n_cmp++;
        if (vs_cnt != 2 * C_VS * C_HT) begin n_bad++; $display("FAIL vsync_pixels: got %0d want %0d", vs_cnt, 2 * C_VS * C_HT); end
        n_cmp++;
        if (hs_cnt != 2 * C_HS * C_VT) begin n_bad++; $display("FAIL hsync_pixels: got %0d want %0d", hs_cnt, 2 * C_HS * C_VT); end
        n_cmp++;
        if (wraps != 1) begin n_bad++; $display("FAIL wrap_count: got %0d want 1", wraps); end
    endtask

    task automatic test_midframe_reset;
        logic found;
        found = 1'b0;
        do_reset(2, RED);
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (ifc.pix_en === 1'b1 && ifc.pixel_x === 16'd5 && ifc.pixel_y === 16'd4) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin n_bad++; $display("FAIL midframe_reach: got no (5,4) pulse, want one within 2000 clks"); end
        @(posedge clk); #2; rst_c = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({ifc.pix_en, ifc.pixel_x, ifc.pixel_y, ifc.frame_start, ifc.blank, ifc.hsync, ifc.vsync, ifc.rgb_out}
            !== {1'b0, 16'd0, 16'd0, 1'b0, 3'b100, 24'h0}) begin
            n_bad++; $display("FAIL midframe_reset: got x=%0d y=%0d blank=%b hs=%b vs=%b rgb=%h, want 0/0/1/0/0/000000",
                              ifc.pixel_x, ifc.pixel_y, ifc.blank, ifc.hsync, ifc.vsync, ifc.rgb_out);
        end
        @(posedge clk); #2; rst_c = 1'b0;
        repeat (C_DIV) @(negedge clk);
        n_cmp++;
        if ({ifc.pix_en, ifc.pixel_x, ifc.pixel_y, ifc.frame_start} !== {1'b1, 16'd0, 16'd0, 1'b1}) begin
            n_bad++; $display("FAIL midframe_restart: got pe=%b x=%0d y=%0d fs=%b, want 1/0/0/1",
                              ifc.pix_en, ifc.pixel_x, ifc.pixel_y, ifc.frame_start);
        end
    endtask

    task automatic test_div1;
        int pe_cnt, hs_cnt, blk_cnt, first_hs, px;
        pe_cnt = 0; hs_cnt = 0; blk_cnt = 0; first_hs = -1; px = 0;
        do_reset(1, GREEN);
        for (int i = 0; i <= VGA_H_TOTAL; i++) begin
            @(negedge clk);
            if (i > 0) begin
                if (ifb.hsync === 1'b0) begin hs_cnt++; if (first_hs < 0) first_hs = px; end
                if (ifb.blank === 1'b1) blk_cnt++;
            end
            if (ifb.pix_en === 1'b1) pe_cnt++;
            px = int'(ifb.pixel_x);
        end
        n_cmp++;
        if (pe_cnt != VGA_H_TOTAL + 1) begin n_bad++; $display("FAIL div1_pix_en: got %0d want %0d", pe_cnt, VGA_H_TOTAL + 1); end
        n_cmp++;
        if (hs_cnt != 96 || first_hs != 656) begin
            n_bad++; $display("FAIL div1_hsync: got %0d from %0d want 96 from 656", hs_cnt, first_hs);
        end
        n_cmp++;
        if (blk_cnt != 160) begin n_bad++; $display("FAIL div1_blank: got %0d want 160", blk_cnt); end
        n_cmp++;
        if (ifb.pixel_x !== 16'd0 || ifb.pixel_y !== 16'd1) begin
            n_bad++; $display("FAIL div1_line_period: got x=%0d y=%0d want 0/1", ifb.pixel_x, ifb.pixel_y);
        end
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        test_reset();
        test_line();
        test_blue();
        test_back_to_back();
        test_frame();
        test_midframe_reset();
        test_div1();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
